// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package arb_pkg;
    localparam int N            = 8;
    localparam int IDXW         = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;
endpackage

// File: rtl/rr_arbiter8_prio_enc8.sv
// Lowest-index-first 8->3 priority encoder with an any-set flag.
module prio_enc8
    import arb_pkg::*;
(
    input  logic [N-1:0]    in,
    output logic [IDXW-1:0] idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        any = |in;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) idx = IDXW'(i);
        end
    end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered grant, release
// handshake and hold-timeout preemption.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            preempt
);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [7:0]      hcnt_q, hcnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            vld_q, vld_d;
    logic            pre_q, pre_d;

    logic [N-1:0]    req_rot;
    logic [IDXW-1:0] enc_idx;
    logic            enc_any;
    logic [IDXW-1:0] winner;
    logic            others;

    // Rotate right by ptr: bit i of the rotated vector is requester (ptr+i) mod 8.
    always_comb begin
        req_rot = '0;
        for (int i = 0; i < N; i++) begin
            req_rot[i] = req[ptr_q + IDXW'(i)];
        end
    end

    prio_enc8 u_enc (
        .in  (req_rot),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign winner = enc_idx + ptr_q;
    assign others = |(req & ~gnt_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        pre_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    gnt_d   = N'(1) << winner;
                    idx_d   = winner;
                    vld_d   = 1'b1;
                    hcnt_d  = '0;
                    ptr_d   = winner + IDXW'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Release wins over timeout when both happen together.
                if (!req[idx_q]) begin
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end else if (hcnt_q == HOLD_LAST && others) begin
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                    pre_d   = 1'b1;
                    state_d = IDLE;
                end else if (hcnt_q != HOLD_LAST) begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hcnt_q  <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            pre_q   <= pre_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = vld_q;
    assign preempt   = pre_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus a random run
// checked against a queue-free behavioural model of the arbitration rules.
module tb_rr_arbiter8;
    localparam int MH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int total = 0;
    int bad   = 0;

    // Reference model: current owner (-1 = none), next-priority position,
    // number of grant cycles the owner has had, and the preempt pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_pre   = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic model_update(input logic [7:0] r);
        m_pre = 1'b0;
        if (m_owner < 0) begin
            if (r != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    int c;
                    c = (m_ptr + k) % 8;
                    if (r[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_ptr  = (m_owner + 1) % 8;
                m_held = 1;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (m_held >= MH && (r & ~(8'(1) << m_owner)) != 8'h00) begin
            m_owner = -1;
            m_pre   = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic step(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_update(r);
        #1;
    endtask

    task automatic do_reset();
        req = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_pre   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        @(posedge clk);
        #1;
        total++;
        if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: gnt=%h idx=%0d vld=%b pre=%b expected all zero",
                     gnt, gnt_idx, gnt_valid, preempt);
        end
        do_reset();
        for (int n = 0; n < 5; n++) begin
            step(8'h00);
            total++;
            if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
                bad++;
                $display("FAIL idle_no_req cyc=%0d: gnt=%h idx=%0d vld=%b pre=%b expected all zero",
                         n, gnt, gnt_idx, gnt_valid, preempt);
            end
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            int e;
            e = (n % 2 == 0) ? 0 : 2;
            step(8'h05);
            total++;
            if (gnt !== 8'(1 << e) || gnt_idx !== 3'(e) || gnt_valid !== 1'b1) begin
                bad++;
                $display("FAIL alt_grant n=%0d: gnt=%h idx=%0d vld=%b expected gnt=%h idx=%0d",
                         n, gnt, gnt_idx, gnt_valid, 8'(1 << e), e);
            end
            step(8'h05);
            step(8'h05);
            total++;
            if (gnt !== 8'(1 << e) || gnt_idx !== 3'(e)) begin
                bad++;
                $display("FAIL alt_hold n=%0d: gnt=%h idx=%0d expected gnt=%h idx=%0d",
                         n, gnt, gnt_idx, 8'(1 << e), e);
            end
            step(8'h05 & ~8'(1 << e));
            total++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
                bad++;
                $display("FAIL alt_gap n=%0d: gnt=%h vld=%b pre=%b expected idle",
                         n, gnt, gnt_valid, preempt);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 9; n++) begin
            int e;
            e = n % 8;
            step(8'hFF);
            total++;
            if (gnt !== 8'(1 << e) || gnt_idx !== 3'(e) || gnt_valid !== 1'b1) begin
                bad++;
                $display("FAIL wrap_grant n=%0d: gnt=%h idx=%0d expected idx=%0d",
                         n, gnt, gnt_idx, e);
            end
            step(8'hFF & ~8'(1 << e));
            total++;
            if (gnt !== 8'h00 || preempt !== 1'b0) begin
                bad++;
                $display("FAIL wrap_release n=%0d: gnt=%h pre=%b expected gnt=00 pre=0",
                         n, gnt, preempt);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        step(8'h08);
        for (int k = 1; k < MH; k++) begin
            step((k >= 4) ? 8'h28 : 8'h08);
            total++;
            if (gnt !== 8'h08 || preempt !== 1'b0) begin
                bad++;
                $display("FAIL timeout_hold cyc=%0d: gnt=%h pre=%b expected gnt=08 pre=0",
                         k + 1, gnt, preempt);
            end
        end
        step(8'h28);
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || preempt !== 1'b1) begin
            bad++;
            $display("FAIL timeout_preempt: gnt=%h vld=%b pre=%b expected gnt=00 vld=0 pre=1",
                     gnt, gnt_valid, preempt);
        end
        step(8'h28);
        total++;
        if (gnt !== 8'h20 || gnt_idx !== 3'd5 || preempt !== 1'b0) begin
            bad++;
            $display("FAIL timeout_next: gnt=%h idx=%0d pre=%b expected gnt=20 idx=5 pre=0",
                     gnt, gnt_idx, preempt);
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step(8'h08);
            total++;
            if (gnt !== 8'h08 || gnt_idx !== 3'd3 || preempt !== 1'b0) begin
                bad++;
                $display("FAIL solo_hold cyc=%0d: gnt=%h idx=%0d pre=%b expected gnt=08 idx=3 pre=0",
                         k, gnt, gnt_idx, preempt);
            end
        end
    endtask

    task automatic test_reset_midgrant(input int owner);
        int e;
        do_reset();
        step(8'(1 << owner));
        step(8'(1 << owner));
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset owner=%0d: gnt=%h idx=%0d vld=%b expected all zero",
                     owner, gnt, gnt_idx, gnt_valid);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_pre   = 1'b0;
        e = 0;
        step(8'h41);
        total++;
        if (gnt !== 8'(1 << e) || gnt_idx !== 3'(e)) begin
            bad++;
            $display("FAIL ptr_after_reset owner=%0d: gnt=%h idx=%0d expected gnt=01 idx=0",
                     owner, gnt, gnt_idx);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic [7:0] eg;
        logic [2:0] ei;
        do_reset();
        r = 8'h00;
        for (int n = 0; n < 600; n++) begin
            r = r ^ 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 29) == 0) r = 8'h00;
            step(r);
            eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
            ei = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
            total++;
            if (gnt !== eg || gnt_idx !== ei || gnt_valid !== (m_owner >= 0) || preempt !== m_pre) begin
                bad++;
                $display("FAIL random cyc=%0d req=%h: gnt=%h idx=%0d vld=%b pre=%b expected gnt=%h idx=%0d vld=%b pre=%b",
                         n, r, gnt, gnt_idx, gnt_valid, preempt, eg, ei, (m_owner >= 0), m_pre);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_wrap();
        test_timeout();
        test_no_preempt();
        test_reset_midgrant(6);
        test_reset_midgrant(2);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one downstream resource among eight requesters using a registered request/grant handshake. Each cycle it picks the next requester at or after a rotating priority pointer, encodes the winner into a one-hot grant and a 3-bit index, and holds the grant until the owner releases or a hold timeout forces preemption. It sits in front of any shared combinational datapath (encoder, ALU, bus) and drives its input-select mux from `gnt_idx`.

## Interface
- `N`, 8: number of requesters; fixed at 8 in this revision.
- `IDXW`, 3: index width, log2(N).
- `MAX_HOLD`, 16: the cycle budget an owner may hold the grant while others wait; legal range 2..255.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  N  per-requester request level; a requester holds its bit high until it is done.
- `gnt`  output  N  one-hot grant, registered; all zeros when nothing is granted.
- `gnt_idx`  output  IDXW  binary index of the current owner; 0 when `gnt_valid`=0.
- `gnt_valid`  output  1  high while any grant bit is set.
- `preempt`  output  1  one-cycle pulse on the cycle a grant is removed by timeout.

## Operation
- Reset values:
  - `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `preempt`=0.
  - State IDLE, pointer `ptr`=0, hold counter `hcnt`=0.
- Arbitration: `req` is rotated right by `ptr`. A fixed-priority encoder picks the lowest set bit of the rotated vector. The winner is `(enc + ptr) mod 8`.
  - Example: with `ptr`=6 and `req`=8'b0100_0001, requester 6 wins. With `ptr`=7 and the same `req`, requester 0 wins.
- States:
  - IDLE: if `req`≠0, register winner into `gnt`/`gnt_idx`, set `gnt_valid`, `hcnt`=0, and go to GRANT. If `req`=0, stay in IDLE and keep outputs at zero.
  - GRANT, normal release: if `req[gnt_idx]`=0, clear `gnt` and go to IDLE.
  - GRANT, timeout: if `hcnt`=MAX_HOLD-1 and any other `req` bit is set, clear `gnt`, pulse `preempt`, and go to IDLE.
  - GRANT, otherwise: `hcnt` increments and saturates at MAX_HOLD-1. If no one else is waiting, the owner keeps the grant indefinitely.
- Pointer: when a grant is issued to requester i, `ptr` becomes `(i+1) mod 8`. This is 3-bit wrap-around, so 7 becomes 0.
- A preempted requester keeps `req` high. It re-competes normally and gets lowest priority after its own grant.
- Simultaneous release and timeout in the same cycle count as a normal release: no `preempt` pulse.
- Changes to `req` bits other than the owner's have no effect while in GRANT, except for the timeout check.
- Reset asserted mid-grant: outputs clear immediately (asynchronously) and `ptr` returns to 0.

## Timing
- Grant latency: a request sampled in IDLE at edge t produces `gnt` valid after edge t. The first cycle a grant is visible is the cycle after `req` is seen.
- Release latency: when `req[owner]` falls before edge t, `gnt` is 0 after edge t.
  - At least one cycle of `gnt`=0 always separates consecutive grants, because re-arbitration happens in IDLE. Back-to-back owner handoff therefore takes 2 cycles.
- Timeout: the owner holds for exactly MAX_HOLD cycles of `gnt_valid` before preemption, provided contention exists throughout.
  - `preempt` is high in the first cycle `gnt`=0.
- All outputs are registered; there is no combinational path from `req` to `gnt`.

## Structure
- Package `arb_pkg`:
  - `N`, `IDXW` constants.
  - State enum `{IDLE, GRANT}`.
  - `MAX_HOLD` default.
- Sub-module `prio_enc8`: combinational 8→3 lowest-index-first priority encoder with an `any` valid output. It is instanced once on the rotated request vector.
- Rotation, FSM, pointer and hold counter live in `rr_arbiter8`.

## Test plan
- Reset, then `req`=8'h00 for 5 cycles → `gnt`=0, `gnt_valid`=0, `preempt`=0 throughout.
- `req`=8'b0000_0101 held; each owner drops `req` for one cycle after 3 cycles of grant → grants alternate 0, 2, 0, 2.
  - `gnt_idx` follows the same sequence.
  - There is one idle cycle between each grant.
- `req`=8'hFF with every owner releasing after 1 cycle → grant order 0,1,…,7,0. This exercises `ptr` wrap from 7 to 0.
- MAX_HOLD=16: requester 3 holds `req` permanently and requester 5 requests at cycle 4 of the grant → after 16 grant cycles, `gnt` goes to 0 with `preempt`=1. The next cycle grants 5.
- Requester 3 alone with `req` held for 40 cycles → no preemption, `gnt`=8'b0000_1000 continuously.
- Assert `rst` for 1 cycle mid-grant to requester 6 → `gnt`=0 immediately. With `req`=8'b0100_0001 after reset, requester 0 wins because `ptr`=0.
